// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the Avalon memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RDLAT, RESP} state_t;
  typedef enum logic {FETCH, DATA} grant_t;
  localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/avalon_mem_arbiter_if.sv
// avalon_mem_arbiter_if: Avalon-MM master port bundle between the arbiter and the memory slave
interface avalon_mem_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );
  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts consecutive stall cycles and flags the one that reaches TIMEOUT
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : cnt_q + TW'(inc);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // hit fires during the stall cycle that would bring the count to TIMEOUT
  assign hit = (TIMEOUT > 0) && inc && (cnt_q == TW'(TIMEOUT - 1));
endmodule

// File: rtl/avalon_mem_arbiter.sv
// avalon_mem_arbiter: round-robin sharing of one Avalon-MM master between fetch and data requesters
module avalon_mem_arbiter import mem_arb_pkg::*; #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        busy,
  avalon_mem_arbiter_if.master avm
);
  state_t      state_q, state_d;
  grant_t      grant_q, grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        busy_q, busy_d;
  logic        wd_hit;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wd (
    .clk,
    .reset,
    .clr (state_q == RESP),
    .inc (state_q == ACCESS && avm.waitrequest),
    .hit (wd_hit)
  );

  // grant_q doubles as last_grant: it holds the most recent winner until the next IDLE decision
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    read_d  = read_q;
    write_d = write_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (i_req || d_req) begin
        grant_d = (i_req && d_req) ? ((grant_q == FETCH) ? DATA : FETCH) : (d_req ? DATA : FETCH);
        addr_d  = ((grant_d == DATA) ? d_addr : i_addr) & ~32'h3;
        we_d    = (grant_d == DATA) && d_we;
        wdata_d = (grant_d == DATA) ? d_wdata : '0;
        be_d    = (grant_d == DATA) ? d_be : BE_WORD;
        read_d  = !we_d;
        write_d = we_d;
        state_d = ACCESS;
      end
      ACCESS: if (!avm.waitrequest || wd_hit) begin
        read_d  = 1'b0;
        write_d = 1'b0;
        err_d   = avm.waitrequest;
        state_d = (we_q || avm.waitrequest) ? RESP : RDLAT;
      end
      RDLAT: state_d = RESP;
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign i_ack_d   = (state_d == RESP) && (grant_q == FETCH);
  assign d_ack_d   = (state_d == RESP) && (grant_q == DATA);
  assign i_rdata_d = (state_q == RDLAT && grant_q == FETCH) ? avm.readdata : '0;
  assign d_rdata_d = (state_q == RDLAT && grant_q == DATA) ? avm.readdata : '0;
  assign busy_d    = state_d != IDLE;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= FETCH;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      read_q    <= read_d;
      write_q   <= write_d;
      err_q     <= err_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end

  assign avm.address    = addr_q;
  assign avm.read       = read_q;
  assign avm.write      = write_q;
  assign avm.writedata  = wdata_q;
  assign avm.byteenable = be_q;
  assign i_ack          = i_ack_q;
  assign d_ack          = d_ack_q;
  assign i_rdata        = i_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign err            = err_q;
  assign busy           = busy_q;
endmodule
